// File: rtl/test_fifo_stream_reader.sv
// Pop-side drain engine for a 1-cycle-latency sync FIFO wrapper.
// It issues fifo_rd, captures fifo_dout on fifo_rd_vld into a 2-entry skid
// buffer, and presents the buffer head as a valid/ready stream.
module test_fifo_stream_reader #(
  parameter int WIDTH       = 16,
  parameter bit SINGLE_PORT = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             fifo_mt,
  input  logic             fifo_wr,
  output logic             fifo_rd,
  input  logic             fifo_rd_vld,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  logic [1:0][WIDTH-1:0] skid_q, skid_d;
  logic [1:0]            stored_q, stored_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  inflight_q, inflight_d;
  logic                  err_q, err_d;

  logic [1:0] occ;
  logic       push, pop, ovf;

  // Issue logic: only registered state plus fifo_mt/fifo_wr, so there is no
  // combinational path from out_rdy to fifo_rd. Held low while in reset.
  always_comb begin
    occ     = stored_q + {1'b0, inflight_q};
    fifo_rd = reset_n && !fifo_mt && (occ < 2'd2) && !(SINGLE_PORT && fifo_wr);
    out_vld  = (stored_q != 2'd0);
    out_data = skid_q[rd_ptr_q];
    out_err  = err_q;
  end

  // Next-state: capture returned data, advance pointers, track occupancy and errors.
  always_comb begin
    skid_d     = skid_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    stored_d   = stored_q;
    inflight_d = fifo_rd;
    err_d      = err_q;

    pop  = out_vld && out_rdy;
    // A full buffer cannot take returning data; the word is dropped and flagged.
    ovf  = fifo_rd_vld && (stored_q == 2'd2);
    push = fifo_rd_vld && !ovf;

    if (push) begin
      skid_d[wr_ptr_q] = fifo_dout;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;

    stored_d = stored_q + {1'b0, push} - {1'b0, pop};

    if ((fifo_rd_vld && !inflight_q) || ovf) err_d = 1'b1;
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_q     <= '0;
      stored_q   <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      skid_q     <= skid_d;
      stored_q   <= stored_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_test_fifo_stream_reader.sv
// Bench for test_fifo_stream_reader: behavioural FIFO wrapper model, directed
// stimulus, and a scoreboard queue checked by an independent output monitor.
module tb_test_fifo_stream_reader;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         fifo_mt, fifo_wr, fifo_rd, fifo_rd_vld;
  logic [W-1:0] fifo_dout, wr_data;
  logic         out_vld, out_rdy, out_err;
  logic [W-1:0] out_data;
  logic         inj;
  logic [W-1:0] inj_data;

  int checks = 0, errors = 0;
  int rd_cnt = 0, cyc = 0, first_rd = -1, first_vld = -1;
  bit sp_mode = 1'b0;

  logic [W-1:0] mem[$];
  logic [W-1:0] exp_q[$];

  test_fifo_stream_reader #(.WIDTH(W), .SINGLE_PORT(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .fifo_mt(fifo_mt), .fifo_wr(fifo_wr),
    .fifo_rd(fifo_rd), .fifo_rd_vld(fifo_rd_vld), .fifo_dout(fifo_dout),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO wrapper model: registered empty flag, read data one cycle after fifo_rd.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem.delete();
      fifo_rd_vld <= 1'b0;
      fifo_dout   <= '0;
      fifo_mt     <= 1'b1;
    end else begin
      if (fifo_wr) mem.push_back(wr_data);
      if (fifo_rd && mem.size() > 0) begin
        fifo_dout   <= mem.pop_front();
        fifo_rd_vld <= 1'b1;
      end else if (inj) begin
        fifo_dout   <= inj_data;
        fifo_rd_vld <= 1'b1;
      end else begin
        fifo_rd_vld <= 1'b0;
      end
      fifo_mt <= (mem.size() == 0);
    end
  end

  // Monitor: samples mid-cycle, pops the scoreboard on every handshake.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset_n) begin
      if (fifo_rd) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (out_vld && first_vld < 0) first_vld = cyc;
      if (sp_mode) begin
        checks++;
        if (fifo_rd && fifo_wr) begin
          errors++;
          $display("FAIL sp_conflict fifo_rd=%0b fifo_wr=%0b required not both", fifo_rd, fifo_wr);
        end
      end
      if (out_vld && out_rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word got=%04h required=none", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL stream_data got=%04h required=%04h", out_data, e);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wr_word(input logic [W-1:0] d);
    fifo_wr = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    tick();
    fifo_wr = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    tick(3);
    chk("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running required=finished");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; fifo_wr = 1'b0; wr_data = '0; out_rdy = 1'b0;
    inj = 1'b0; inj_data = '0;
    tick(2);
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", out_err, 0);
    reset_n = 1'b1;
    tick(2);

    // Four words with the consumer always ready.
    out_rdy = 1'b1; rd_cnt = 0; first_rd = -1; first_vld = -1;
    for (int i = 1; i <= 4; i++) wr_word(W'(i));
    drain();
    chk("t1_rd_cnt", rd_cnt, 4);
    chk("t1_latency", first_vld - first_rd, 2);
    chk("t1_out_vld_idle", out_vld, 0);
    chk("t1_out_err", out_err, 0);

    // Backpressure: only two reads may be outstanding against a stalled consumer.
    out_rdy = 1'b0; rd_cnt = 0;
    for (int i = 1; i <= 8; i++) wr_word(W'(i));
    tick(10);
    chk("t2_rd_cnt_stalled", rd_cnt, 2);
    chk("t2_out_vld_hold", out_vld, 1);
    chk("t2_out_data_hold", out_data, 16'h0001);
    tick(3);
    chk("t2_out_data_stable", out_data, 16'h0001);
    out_rdy = 1'b1;
    drain();
    chk("t2_rd_cnt_total", rd_cnt, 8);

    // Single-port arbitration: writes every other cycle, reads must avoid them.
    wr_word(16'h0010);
    wr_word(16'h0011);
    sp_mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_word(16'h0020 + W'(i));
      tick();
    end
    drain();
    sp_mode = 1'b0;

    // Single entry: exactly one read, stream goes idle, no error.
    rd_cnt = 0;
    wr_word(16'hBEEF);
    tick(8);
    chk("t4_rd_cnt", rd_cnt, 1);
    chk("t4_out_vld", out_vld, 0);
    chk("t4_out_err", out_err, 0);
    chk("t4_scoreboard", exp_q.size(), 0);

    // Reset with two words stored.
    out_rdy = 1'b0; rd_cnt = 0;
    for (int i = 0; i < 4; i++) wr_word(16'h00A0 + W'(i));
    tick(6);
    chk("t6_rd_cnt", rd_cnt, 2);
    chk("t6_out_vld_pre", out_vld, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_out_vld", out_vld, 0);
    chk("t6_rst_fifo_rd", fifo_rd, 0);
    chk("t6_rst_out_data", out_data, 0);
    exp_q.delete();
    tick(2);
    reset_n = 1'b1;
    tick(2);
    out_rdy = 1'b1;
    for (int i = 1; i <= 4; i++) wr_word(16'h0030 + W'(i));
    drain();
    chk("t6_out_err", out_err, 0);

    // Unsolicited read data: sticky error until reset.
    inj_data = 16'h5A5A;
    exp_q.push_back(16'h5A5A);
    inj = 1'b1;
    tick();
    inj = 1'b0;
    tick();
    chk("t5_err_set", out_err, 1);
    tick(5);
    chk("t5_err_sticky", out_err, 1);
    chk("t5_scoreboard", exp_q.size(), 0);
    reset_n = 1'b0;
    #1;
    chk("t5_err_cleared", out_err, 0);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
